cpu_dmem_arbiter: RTL

CPU_DMEM_ARBITER -- requirements
Module: cpu_dmem_arbiter

---
 rtl/cpu_dmem_arbiter.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/cpu_dmem_arbiter.sv
// Two-port round-robin arbiter onto a 16-bit big-endian data bus; long accesses split into two beats.
// Optional beat timeout enabled by defining MOX125_DMEM_TIMEOUT_EN.
module cpu_dmem_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        reqa_i,
  input  logic        reqa_we_i,
  input  logic [1:0]  reqa_size_i,
  input  logic [31:0] reqa_addr_i,
  input  logic [31:0] reqa_data_i,
  input  logic        reqb_i,
  input  logic        reqb_we_i,
  input  logic [1:0]  reqb_size_i,
  input  logic [31:0] reqb_addr_i,
  input  logic [31:0] reqb_data_i,
  output logic        acka_o,
  output logic        ackb_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        busy_o,
  output logic [31:0] dmem_address_o,
  output logic [15:0] dmem_data_o,
  input  logic [15:0] dmem_data_i,
  output logic [1:0]  dmem_sel_o,
  output logic        dmem_stb_o,
  output logic        dmem_cyc_o,
  output logic        dmem_we_o,
  input  logic        dmem_ack_i,
  output logic [1:0]  dbg_state_o
);

  // Handshake: a requester raises req with stable fields and keeps them until
  // its one-cycle ack pulse; it drops req during that ack cycle.
  typedef enum logic [1:0] {IDLE = 2'd0, BEAT1 = 2'd1, BEAT2 = 2'd2, DONE = 2'd3} state_t;

  state_t      state;
  logic        grant_b;
  logic        last_b;
  logic        we_q;
  logic        byte_q;
  logic        long_q;
  logic        err_q;
  logic [31:0] addr_q;
  logic [15:0] lo_q;
  logic [15:0] rhi_q;
  logic        timed_out;

  logic        sel_b;
  logic        r_we;
  logic [1:0]  r_size;
  logic [31:0] r_addr;
  logic [31:0] r_data;
  logic        r_byte;
  logic        r_long;
  logic [31:0] b1_addr;
  logic [15:0] b1_data;
  logic [1:0]  b1_sel;

  // B wins when it is alone or when A was the previous grant.
  assign sel_b  = reqb_i & (~reqa_i | ~last_b);
  assign r_we   = sel_b ? reqb_we_i   : reqa_we_i;
  assign r_size = sel_b ? reqb_size_i : reqa_size_i;
  assign r_addr = sel_b ? reqb_addr_i : reqa_addr_i;
  assign r_data = sel_b ? reqb_data_i : reqa_data_i;
  assign r_byte = (r_size == 2'b00);
  assign r_long = r_size[1];

  always_comb begin
    b1_addr = {r_addr[31:1], 1'b0};
    b1_sel  = 2'b11;
    b1_data = r_long ? r_data[31:16] : r_data[15:0];
    if (r_byte) begin
      b1_addr = r_addr;
      b1_sel  = r_addr[0] ? 2'b01 : 2'b10;
      b1_data = r_addr[0] ? {8'h00, r_data[7:0]} : {r_data[7:0], 8'h00};
    end
  end

`ifdef MOX125_DMEM_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] tcnt;

  // Restarts from zero whenever a beat is entered or completes.
  always_ff @(posedge clk_i) begin
    if (rst_i || dmem_ack_i || !(state == BEAT1 || state == BEAT2))
      tcnt <= '0;
    else
      tcnt <= tcnt + 1'b1;
  end

  assign timed_out = (tcnt == TW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_cfg;
  assign unused_cfg = ^TIMEOUT_CYCLES;
  assign timed_out  = 1'b0;
`endif

  assign dbg_state_o = state;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= IDLE;
      last_b         <= 1'b1;
      grant_b        <= 1'b0;
      we_q           <= 1'b0;
      byte_q         <= 1'b0;
      long_q         <= 1'b0;
      err_q          <= 1'b0;
      addr_q         <= '0;
      lo_q           <= '0;
      rhi_q          <= '0;
      acka_o         <= 1'b0;
      ackb_o         <= 1'b0;
      rdata_o        <= '0;
      err_o          <= 1'b0;
      busy_o         <= 1'b0;
      dmem_address_o <= '0;
      dmem_data_o    <= '0;
      dmem_sel_o     <= '0;
      dmem_stb_o     <= 1'b0;
      dmem_cyc_o     <= 1'b0;
      dmem_we_o      <= 1'b0;
    end else begin
      acka_o <= 1'b0;
      ackb_o <= 1'b0;
      err_o  <= 1'b0;
      case (state)
        IDLE: begin
          if (reqa_i || reqb_i) begin
            grant_b        <= sel_b;
            last_b         <= sel_b;
            we_q           <= r_we;
            byte_q         <= r_byte;
            long_q         <= r_long;
            err_q          <= 1'b0;
            addr_q         <= r_addr;
            lo_q           <= r_data[15:0];
            dmem_address_o <= b1_addr;
            dmem_data_o    <= b1_data;
            dmem_sel_o     <= b1_sel;
            dmem_we_o      <= r_we;
            dmem_stb_o     <= 1'b1;
            dmem_cyc_o     <= 1'b1;
            busy_o         <= 1'b1;
            state          <= BEAT1;
          end
        end
        BEAT1: begin
          if (dmem_ack_i) begin
            if (long_q) begin
              dmem_address_o <= {addr_q[31:1], 1'b0} + 32'd2;
              dmem_data_o    <= lo_q;
              rhi_q          <= dmem_data_i;
              state          <= BEAT2;
            end else begin
              dmem_stb_o <= 1'b0;
              dmem_cyc_o <= 1'b0;
              if (!we_q) begin
                if (byte_q)
                  rdata_o <= {24'h0, addr_q[0] ? dmem_data_i[7:0] : dmem_data_i[15:8]};
                else
                  rdata_o <= {16'h0, dmem_data_i};
              end
              state <= DONE;
            end
          end else if (timed_out) begin
            dmem_stb_o <= 1'b0;
            dmem_cyc_o <= 1'b0;
            err_q      <= 1'b1;
            state      <= DONE;
          end
        end
        BEAT2: begin
          if (dmem_ack_i) begin
            dmem_stb_o <= 1'b0;
            dmem_cyc_o <= 1'b0;
            if (!we_q)
              rdata_o <= {rhi_q, dmem_data_i};
            state <= DONE;
          end else if (timed_out) begin
            dmem_stb_o <= 1'b0;
            dmem_cyc_o <= 1'b0;
            err_q      <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          acka_o <= ~grant_b;
          ackb_o <= grant_b;
          err_o  <= err_q;
          busy_o <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule
